// File: rtl/aclk_controller_param.sv
// Alarm-clock keypad/display controller: sequences digit entry, rejects short
// entries, times out idle entries and selects one of NUM_ALARMS alarm slots.
module aclk_controller_param #(
    parameter int KEY_W       = 4,
    parameter int NO_KEY      = 10,
    parameter int NUM_DIGITS  = 4,
    parameter int TIMEOUT_SEC = 10,
    parameter int NUM_ALARMS  = 2,
    localparam int AW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             one_second,
    input  logic             alarm_button,
    input  logic             time_button,
    input  logic             alarm_sel_button,
    input  logic [KEY_W-1:0] key,
    output logic             reset_count,
    output logic             load_new_c,
    output logic             show_new_time,
    output logic             show_a,
    output logic             load_new_a,
    output logic [AW-1:0]    alarm_idx,
    output logic             shift,
    output logic [3:0]       digit_count,
    output logic             entry_err
);

    localparam logic [KEY_W-1:0] IDLE_KEY = KEY_W'(NO_KEY);
    localparam logic [3:0]       DIGITS   = 4'(NUM_DIGITS);
    localparam logic [7:0]       TMO      = 8'(TIMEOUT_SEC);
    localparam logic [AW-1:0]    LAST_IDX = AW'(NUM_ALARMS - 1);

    typedef enum logic [6:0] {
        S_SHOW_TIME   = 7'b0000001,
        S_KEY_STORED  = 7'b0000010,
        S_KEY_WAITED  = 7'b0000100,
        S_KEY_ENTRY   = 7'b0001000,
        S_SHOW_ALARM  = 7'b0010000,
        S_SET_ALARM   = 7'b0100000,
        S_SET_CURRENT = 7'b1000000
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      timer_q, timer_d;
    logic [3:0]      dcnt_q, dcnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            err_q, err_d;
    logic            key_hit;
    logic            timeout;
    logic            complete;
    logic            in_entry;

    assign key_hit  = (key != IDLE_KEY);
    assign timeout  = (timer_q == TMO);
    assign complete = (dcnt_q == DIGITS);
    assign in_entry = (state_q == S_KEY_WAITED) || (state_q == S_KEY_ENTRY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_SHOW_TIME;
            timer_q <= '0;
            dcnt_q  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dcnt_q  <= dcnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        timer_d = timer_q;
        case (state_q)
            S_SHOW_TIME: begin
                dcnt_d = '0;
                if (alarm_button)
                    state_d = S_SHOW_ALARM;
                else if (key_hit)
                    state_d = S_KEY_STORED;
            end
            S_KEY_STORED: begin
                state_d = S_KEY_WAITED;
                dcnt_d  = (dcnt_q >= DIGITS) ? DIGITS : 4'(dcnt_q + 4'd1);
            end
            S_KEY_WAITED: begin
                if (!key_hit)
                    state_d = S_KEY_ENTRY;
                else if (timeout)
                    state_d = S_SHOW_TIME;
            end
            S_KEY_ENTRY: begin
                // alarm outranks time so a simultaneous press loads the alarm slot
                if (alarm_button) begin
                    state_d = complete ? S_SET_ALARM : S_SHOW_TIME;
                    err_d   = !complete;
                end else if (time_button) begin
                    state_d = complete ? S_SET_CURRENT : S_SHOW_TIME;
                    err_d   = !complete;
                end else if (timeout) begin
                    state_d = S_SHOW_TIME;
                end else if (key_hit) begin
                    state_d = S_KEY_STORED;
                end
            end
            S_SET_ALARM, S_SET_CURRENT: state_d = S_SHOW_TIME;
            S_SHOW_ALARM: begin
                if (!alarm_button)
                    state_d = S_SHOW_TIME;
                if (alarm_sel_button)
                    idx_d = (idx_q == LAST_IDX) ? '0 : AW'(idx_q + AW'(1));
            end
            default: state_d = S_SHOW_TIME;
        endcase

        // Timer runs only while staying in WAITED/ENTRY; any entry into them restarts it.
        if (in_entry && (state_d == state_q)) begin
            if (one_second && !timeout)
                timer_d = 8'(timer_q + 8'd1);
        end else begin
            timer_d = '0;
        end
    end

    assign reset_count   = (state_q == S_SET_CURRENT);
    assign load_new_c    = (state_q == S_SET_CURRENT);
    assign load_new_a    = (state_q == S_SET_ALARM);
    assign show_a        = (state_q == S_SHOW_ALARM);
    assign shift         = (state_q == S_KEY_STORED);
    assign show_new_time = (state_q == S_KEY_STORED) || in_entry;
    assign alarm_idx     = idx_q;
    assign digit_count   = dcnt_q;
    assign entry_err     = err_q;

endmodule

// File: tb/tb_aclk_controller_param.sv
// Directed bench for aclk_controller_param: expected output vectors are queued
// as each step is driven and compared after the following clock edge.
module tb_aclk_controller_param;

    localparam int K_IDLE  = 0;
    localparam int K_STORE = 1;
    localparam int K_ENTRY = 2;
    localparam int K_SHOWA = 3;
    localparam int K_SETA  = 4;
    localparam int K_SETC  = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       one_second = 1'b0;
    logic       alarm_button = 1'b0;
    logic       time_button = 1'b0;
    logic       alarm_sel_button = 1'b0;
    logic [3:0] key = 4'd10;
    logic       reset_count, load_new_c, show_new_time, show_a, load_new_a;
    logic       shift, entry_err;
    logic [1:0] alarm_idx;
    logic [3:0] digit_count;
    logic [12:0] obs_v;

    aclk_controller_param #(
        .KEY_W(4), .NO_KEY(10), .NUM_DIGITS(4), .TIMEOUT_SEC(10), .NUM_ALARMS(3)
    ) dut (
        .clk(clk), .reset(reset), .one_second(one_second),
        .alarm_button(alarm_button), .time_button(time_button),
        .alarm_sel_button(alarm_sel_button), .key(key),
        .reset_count(reset_count), .load_new_c(load_new_c),
        .show_new_time(show_new_time), .show_a(show_a),
        .load_new_a(load_new_a), .alarm_idx(alarm_idx), .shift(shift),
        .digit_count(digit_count), .entry_err(entry_err)
    );

    always #5 clk = ~clk;

    assign obs_v = {entry_err, shift, show_new_time, show_a, load_new_a,
                    load_new_c, reset_count, alarm_idx, digit_count};

    typedef struct {
        string       tag;
        logic [12:0] val;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    int         shifts = 0;
    int         s0;
    logic [1:0] e_idx = 2'd0;
    logic [3:0] e_dc = 4'd0;
    logic [1:0] sel_seq [4] = '{2'd1, 2'd2, 2'd0, 2'd1};

    always @(posedge clk) if (shift === 1'b1) shifts++;

    function automatic logic [12:0] mk(int kind, logic err, logic [1:0] idx, logic [3:0] dc);
        logic sh, snt, sa, lna, lnc;
        sh = 1'b0; snt = 1'b0; sa = 1'b0; lna = 1'b0; lnc = 1'b0;
        case (kind)
            K_STORE: begin sh = 1'b1; snt = 1'b1; end
            K_ENTRY: snt = 1'b1;
            K_SHOWA: sa = 1'b1;
            K_SETA:  lna = 1'b1;
            K_SETC:  lnc = 1'b1;
            default: ;
        endcase
        return {err, sh, snt, sa, lna, lnc, lnc, idx, dc};
    endfunction

    task automatic push(string tag, int kind, logic err, logic [3:0] dc);
        exp_t e;
        e.tag = tag;
        e.val = mk(kind, err, e_idx, dc);
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL sb_underflow observed=%b required=queued_entry", obs_v);
        end else begin
            e = sb.pop_front();
            assert (obs_v === e.val) else begin
                fails++;
                $error("FAIL %s observed=%b required=%b", e.tag, obs_v, e.val);
            end
        end
    endtask

    task automatic check_val(string tag, int observed, int expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s observed=%0d required=%0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(string tag, int kind, logic err, logic [3:0] dc);
        push(tag, kind, err, dc);
        step();
        check();
    endtask

    task automatic digit(logic [3:0] k);
        key = k;
        cyc("stored", K_STORE, 1'b0, e_dc);
        key = 4'd10;
        e_dc = (e_dc < 4'd4) ? e_dc + 4'd1 : 4'd4;
        cyc("waited", K_ENTRY, 1'b0, e_dc);
        cyc("entry", K_ENTRY, 1'b0, e_dc);
    endtask

    task automatic pulses(int n);
        for (int i = 0; i < n; i++) begin
            one_second = 1'b1;
            cyc("tick", K_ENTRY, 1'b0, e_dc);
            one_second = 1'b0;
            cyc("tick_gap", K_ENTRY, 1'b0, e_dc);
        end
    endtask

    task automatic settle();
        cyc("post_op", K_IDLE, 1'b0, e_dc);
        e_dc = 4'd0;
        cyc("idle_clr", K_IDLE, 1'b0, 4'd0);
    endtask

    initial begin
        // reset state, then idle with no key
        #23;
        push("reset", K_IDLE, 1'b0, 4'd0);
        check();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 20; i++) cyc("idle", K_IDLE, 1'b0, 4'd0);

        // complete 4-digit time entry
        s0 = shifts;
        digit(4'd1); digit(4'd2); digit(4'd3); digit(4'd4);
        time_button = 1'b1;
        cyc("set_time", K_SETC, 1'b0, 4'd4);
        time_button = 1'b0;
        settle();
        check_val("shift_cnt4", shifts - s0, 4);

        // fifth digit saturates the count but still shifts
        s0 = shifts;
        digit(4'd1); digit(4'd2); digit(4'd3); digit(4'd4); digit(4'd5);
        time_button = 1'b1;
        cyc("set_time_sat", K_SETC, 1'b0, 4'd4);
        time_button = 1'b0;
        settle();
        check_val("shift_cnt5", shifts - s0, 5);

        // incomplete entry rejected on alarm_button
        digit(4'd5); digit(4'd6);
        alarm_button = 1'b1;
        cyc("reject_alarm", K_IDLE, 1'b1, 4'd2);
        alarm_button = 1'b0;
        e_dc = 4'd0;
        cyc("after_reject", K_IDLE, 1'b0, 4'd0);

        // slot selection while showing the alarm
        alarm_button = 1'b1;
        cyc("show_alarm", K_SHOWA, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            alarm_sel_button = 1'b1;
            e_idx = sel_seq[i];
            cyc("sel_pulse", K_SHOWA, 1'b0, 4'd0);
            alarm_sel_button = 1'b0;
            cyc("sel_hold", K_SHOWA, 1'b0, 4'd0);
        end
        alarm_button = 1'b0;
        cyc("show_alarm_exit", K_IDLE, 1'b0, 4'd0);
        alarm_sel_button = 1'b1;
        cyc("sel_ignored", K_IDLE, 1'b0, 4'd0);
        alarm_sel_button = 1'b0;

        digit(4'd7); digit(4'd8); digit(4'd9); digit(4'd0);
        alarm_button = 1'b1;
        cyc("set_alarm_slot1", K_SETA, 1'b0, 4'd4);
        alarm_button = 1'b0;
        settle();

        // timeout after the tenth one_second pulse
        digit(4'd3);
        pulses(9);
        one_second = 1'b1;
        cyc("tick10", K_ENTRY, 1'b0, e_dc);
        one_second = 1'b0;
        cyc("timeout", K_IDLE, 1'b0, 4'd1);
        e_dc = 4'd0;
        cyc("after_timeout", K_IDLE, 1'b0, 4'd0);

        // a new key restarts the timer
        digit(4'd3);
        pulses(9);
        digit(4'd4);
        pulses(9);
        time_button = 1'b1;
        cyc("reject_time", K_IDLE, 1'b1, 4'd2);
        time_button = 1'b0;
        e_dc = 4'd0;
        cyc("after_reject2", K_IDLE, 1'b0, 4'd0);

        // both buttons together: alarm wins
        digit(4'd1); digit(4'd2); digit(4'd3); digit(4'd4);
        alarm_button = 1'b1;
        time_button = 1'b1;
        cyc("both_buttons", K_SETA, 1'b0, 4'd4);
        alarm_button = 1'b0;
        time_button = 1'b0;
        settle();

        // asynchronous reset mid-entry
        digit(4'd1); digit(4'd2);
        #2;
        reset = 1'b0;
        #1;
        e_idx = 2'd0;
        e_dc = 4'd0;
        push("reset_mid", K_IDLE, 1'b0, 4'd0);
        check();
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc("after_reset", K_IDLE, 1'b0, 4'd0);
        cyc("after_reset2", K_IDLE, 1'b0, 4'd0);

        check_val("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aclk_controller_param.md
Name: aclk_controller_param

Overview:
Parametrised next-generation alarm-clock keypad/display controller. It sequences keypad digit entry, shows the alarm time, and loads either the current time or one of NUM_ALARMS alarm slots. It sits between the keypad scanner / one-second divider and the key shift register, time counter and alarm registers. Over the single-alarm controller it adds:
- configurable entry length and timeout
- digit counting, with rejection of incomplete entries
- multi-slot alarm selection

Parameters:
KEY_W, 4, keypad code width
NO_KEY, 10, key code meaning "no key pressed"
NUM_DIGITS, 4, digits required for a valid entry (1..15)
TIMEOUT_SEC, 10, one_second pulses before an idle entry is abandoned (2..255)
NUM_ALARMS, 2, alarm slots (1..16); AW = max(1, clog2(NUM_ALARMS))

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
one_second  input  1  single-cycle pulse, once per second
alarm_button  input  1  level, alarm key held
time_button  input  1  level, time-set key held
alarm_sel_button  input  1  single-cycle pulse (edge-detected upstream), advance alarm slot
key  input  KEY_W  current keypad code; NO_KEY when idle
reset_count  output  1  clear seconds counter
load_new_c  output  1  load shift-register value into current time
show_new_time  output  1  display shift register (entry in progress)
show_a  output  1  display alarm slot alarm_idx
load_new_a  output  1  load shift-register value into alarm slot alarm_idx
alarm_idx  output  AW  selected alarm slot
shift  output  1  shift key into key register
digit_count  output  4  digits captured in current entry
entry_err  output  1  one-cycle pulse, incomplete entry rejected

Behaviour:
- Reset (reset=0, async): state=SHOW_TIME, timer=0, digit_count=0, alarm_idx=0, entry_err=0. All outputs 0.
- Mealy-free decode: reset_count=load_new_c=(SET_CURRENT_TIME); load_new_a=(SET_ALARM_TIME); show_a=(SHOW_ALARM); shift=(KEY_STORED); show_new_time=(KEY_STORED|KEY_WAITED|KEY_ENTRY). Each is valid in the cycle the state register holds that state.
- One-hot states, transitions evaluated each clk:
  - SHOW_TIME:
    - alarm_button -> SHOW_ALARM
    - else key!=NO_KEY -> KEY_STORED
    - else stay
    - digit_count forced to 0 while in SHOW_TIME.
  - KEY_STORED: -> KEY_WAITED unconditionally. digit_count <= min(digit_count+1, NUM_DIGITS); once saturated, further keys still shift.
  - KEY_WAITED:
    - key==NO_KEY -> KEY_ENTRY
    - else timeout -> SHOW_TIME
    - else stay
  - KEY_ENTRY, priority order:
    - alarm_button -> SET_ALARM_TIME if digit_count==NUM_DIGITS, else SHOW_TIME with entry_err
    - time_button -> SET_CURRENT_TIME if complete, else SHOW_TIME with entry_err
    - timeout -> SHOW_TIME (no entry_err)
    - key!=NO_KEY -> KEY_STORED
    - else stay
    - Both buttons together: alarm wins.
  - SET_ALARM_TIME, SET_CURRENT_TIME: exactly one cycle, then -> SHOW_TIME.
  - SHOW_ALARM: !alarm_button -> SHOW_TIME, else stay. A single-cycle alarm_sel_button pulse here sets alarm_idx <= (alarm_idx==NUM_ALARMS-1) ? 0 : alarm_idx+1. alarm_sel_button is ignored in every other state.
  - Illegal encoding -> SHOW_TIME.
- Timer (8-bit):
  - Cleared when state is not KEY_WAITED/KEY_ENTRY, and on any transition into either of them (KEY_WAITED->KEY_ENTRY clears it).
  - Otherwise increments on one_second and saturates at TIMEOUT_SEC.
  - timeout = (timer==TIMEOUT_SEC), combinational.
  - A one_second pulse in the clearing cycle is lost.
- entry_err: registered. High for exactly the one cycle after the rejecting KEY_ENTRY cycle, i.e. coincident with the first SHOW_TIME cycle.
- alarm_idx: persists across entries and is unaffected by everything except alarm_sel_button and reset. load_new_a targets the current alarm_idx.
- Reset mid-entry: immediate return to SHOW_TIME; digit_count cleared; no load pulse.

Test Plan:
- Reset then idle (key=10): all outputs 0, alarm_idx=0, state SHOW_TIME for 20 cycles. Assert reset mid-KEY_ENTRY -> outputs drop to 0 asynchronously.
- Keys 1,2,3,4, each one cycle followed by NO_KEY, then time_button -> shift pulses exactly 4 times, digit_count=4, a single-cycle load_new_c=reset_count=1, then SHOW_TIME, entry_err=0.
- Keys 5,6 only, then alarm_button -> no load_new_a, entry_err one cycle, digit_count returns to 0.
- NUM_ALARMS=3: hold alarm_button, issue 4 alarm_sel_button pulses -> alarm_idx 1,2,0,1 and show_a=1 throughout. Release, enter 4 digits, press alarm_button -> load_new_a one cycle with alarm_idx=1.
- TIMEOUT_SEC=10: one key then idle in KEY_ENTRY -> after the 10th one_second pulse the next cycle is SHOW_TIME. With 9 pulses followed by a new key, the timer restarts and no timeout occurs.
- KEY_ENTRY with 4 digits, alarm_button and time_button asserted the same cycle -> load_new_a=1, load_new_c=0.
